store_lane_align: RTL
=====================

# store_lane_align

Store-side counterpart of the load-data extractor: accepts a store request (size, byte address, register data), replicates the data onto the correct byte lanes, and generates a 4-bit byte-enable. It buffers aligned stores in a small FIFO and drains them to the data memory over a req/ack handshake. The block sits between the EX/MEM stage and the data-memory write port, and backpressures the pipeline when full.

## Interface
- `DEPTH`, default 2: store-buffer entries, power of two, ≥2.
- `AW`, default 32: address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `st_valid` in 1: store request valid.
- `st_ready` out 1: buffer can accept a request this cycle.
- `st_size` in 2: size encoding.
  - 2'b11 word, 2'b10 halfword, 2'b01 byte, 2'b00 none.
  - This is the same encoding the load path uses.
- `st_addr` in AW: byte address.
- `st_data` in 32: register data; the low byte/half is significant for sub-word stores.
- `mem_req` out 1: write request to memory.
- `mem_ack` in 1: memory accepted the head entry this cycle.
- `mem_addr` out AW: word address, with [1:0] forced to 0.
- `mem_wdata` out 32: lane-replicated data.
- `mem_be` out 4: byte enables; bit i covers byte [8i+7:8i].
- `buf_empty` out 1: no pending stores.
- `misalign_err` out 1: one-cycle error pulse. Tied to 0 unless the macro below is defined.

## Operation
- **Accept.** A request is accepted on a cycle with `st_valid && st_ready`.
  - `st_ready = (count != DEPTH)`. There is no same-cycle bypass.
- **Size none.** An accepted request with size 2'b00 is consumed and dropped. No entry is made.
- **Lane mapping** (a = `st_addr[1:0]`):
  - Byte: wdata = {4{data[7:0]}}, be = 4'b0001 << a.
  - Half: wdata = {2{data[15:0]}}, be = a[1] ? 4'b1100 : 4'b0011. a[0] is ignored.
  - Word: wdata = data, be = 4'b1111. a is ignored.
- **Buffer.** The FIFO holds {word address, wdata, be} in order. Read/write pointers wrap mod DEPTH. `count` runs 0..DEPTH.
- **Drain FSM.**
  - IDLE: `mem_req` = 0. Move to ISSUE when count becomes nonzero.
  - ISSUE: `mem_req` = 1 with the head entry on the outputs.
    - On `mem_ack`: pop the entry. Stay in ISSUE if another entry remains, else go to IDLE.
- **Output stability.** All mem_* outputs are registered. `mem_addr`/`mem_wdata`/`mem_be` hold stable while `mem_req` is high and `mem_ack` is low.
- **Push and pop together.** Allowed in the same cycle when 0 < count < DEPTH. count is unchanged.
  - When count = DEPTH no push can occur, since ready is low.
- **Ack without req.** `mem_ack` with `mem_req` low is ignored.

## Timing
- Reset values: `st_ready`=1, `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `buf_empty`=1, `misalign_err`=0. FSM is in IDLE and pointers/count are 0.
- Reset mid-operation drops all pending entries immediately, including the entry under request. `mem_req` falls asynchronously.
- Latency: accept at edge N into an empty buffer → `mem_req` high from N+1.
- Ack sampled at edge M:
  - With another entry queued, the next entry is presented from M+1 and `mem_req` stays high (back-to-back).
  - Otherwise `mem_req` is low from M+1.
- `st_ready` reflects count registered at the current edge. After a pop from full, ready rises on the next cycle.
- `buf_empty` = (count == 0), registered.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - An accepted halfword with a[0]=1, or word with a≠0, is not enqueued.
  - `misalign_err` pulses high for exactly one cycle, on the cycle after acceptance.
  - Byte stores never trap.
- `STORE_MISALIGN_TRAP_EN` undefined:
  - Low address bits are truncated as in the lane mapping, and every such store is enqueued.
  - `misalign_err` is constant 0.

## Structure
- Shared package `mem_access_pkg`:
  - size constants SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD.
  - store-entry struct {addr, wdata, be}.
  - The load extractor uses the same constants.
- One combinational sub-module, `store_lane_mux`: size + addr[1:0] + data → wdata, be, misaligned flag.
- FIFO and drain FSM live in the top module.

## Test plan
- **Byte lanes:** byte stores of data 0x000000A5 at addresses 0x100..0x103 → be 0001/0010/0100/1000, wdata 0xA5A5A5A5, mem_addr 0x100.
- **Half/word:** half 0x0000BEEF at 0x202 → be 1100, wdata 0xBEEFBEEF. Word 0x12345678 at 0x300 → be 1111, wdata 0x12345678.
- **Backpressure:**
  - Hold `mem_ack`=0 and push 3 stores, DEPTH=2 → `st_ready` low after 2 accepts and the third waits.
  - Ack one → third accepted; order is preserved at the memory.
- **Back-to-back drain:** 2 queued, ack every cycle → `mem_req` stays high 2 cycles with consecutive entries, then low with `buf_empty`=1.
- **Misalign:**
  - With the macro, a word store at 0x401 → no `mem_req` and a 1-cycle `misalign_err`.
  - Without the macro → mem_addr 0x400, be 1111.
- **Reset mid-request:** `rst_n` low while `mem_req`=1 with 2 entries → `mem_req`=0 immediately; after release, `buf_empty`=1 and no stale request.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared memory-access definitions for the load extractor and store aligner.
// Holds the access-size encoding, the buffered store-entry layout and the
// store drain FSM state type.
package mem_access_pkg;

  // Access size encoding, common to the load and store paths.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  // Address field width of a buffered entry; covers the default address width.
  localparam int unsigned ENTRY_AW = 32;

  // One buffered store: word address, lane-replicated data, byte enables.
  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [DATA_W-1:0]   wdata;
    logic [BE_W-1:0]     be;
  } st_entry_t;

  typedef enum logic {
    DRN_IDLE  = 1'b0,
    DRN_ISSUE = 1'b1
  } drain_state_e;

endpackage

// File: rtl/store_lane_mux.sv
// Combinational store lane mapper: replicates register data onto the byte
// lanes selected by size and the low address bits, and builds byte enables.
// Ports:
//   size         - access size (SZ_* encoding)
//   a            - byte offset within the word (addr[1:0])
//   data         - register data, low byte/half significant for sub-word
//   wdata_c      - lane-replicated write data
//   be_c         - byte enables, bit i covers byte [8i+7:8i]
//   misaligned_c - halfword on an odd offset or word on a nonzero offset
module store_lane_mux
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a,
  input  logic [31:0] data,
  output logic [31:0] wdata_c,
  output logic [3:0]  be_c,
  output logic        misaligned_c
);

  // Lane replication and enable generation per access size.
  always_comb begin
    wdata_c      = '0;
    be_c         = '0;
    misaligned_c = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata_c = {4{data[7:0]}};
        be_c    = 4'b0001 << a;
      end
      SZ_HALF: begin
        wdata_c      = {2{data[15:0]}};
        be_c         = a[1] ? 4'b1100 : 4'b0011;
        misaligned_c = a[0];
      end
      SZ_WORD: begin
        wdata_c      = data;
        be_c         = 4'b1111;
        misaligned_c = (a != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_lane_align.sv
// Store aligner and write buffer: maps store requests onto byte lanes, queues
// them in a DEPTH-entry FIFO and drains the head to data memory over req/ack.
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned half/word stores are
// dropped and flagged with a one-cycle misalign_err pulse.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   st_valid/st_ready     - store request handshake
//   st_size/st_addr/st_data - store request payload
//   mem_req/mem_ack       - memory write handshake
//   mem_addr/mem_wdata/mem_be - head entry presented to memory
//   buf_empty             - no pending stores
//   misalign_err          - misaligned-store pulse (0 without the macro)
module store_lane_align
  import mem_access_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1:0]    st_size,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          buf_empty,
  output logic          misalign_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  st_entry_t     fifo [DEPTH];
  st_entry_t     push_entry;
  st_entry_t     head_q;
  st_entry_t     head_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_inc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  drain_state_e  state;
  drain_state_e  state_nxt;
  logic          mem_req_nxt;
  logic [31:0]   lane_wdata;
  logic [3:0]    lane_be;
  logic          lane_mis;
  logic          accept;
  logic          push;
  logic          pop;

  store_lane_mux u_lane_mux (
    .size         (st_size),
    .a            (st_addr[1:0]),
    .data         (st_data),
    .wdata_c      (lane_wdata),
    .be_c         (lane_be),
    .misaligned_c (lane_mis)
  );

  assign accept     = st_valid && st_ready;
  assign pop        = (state == DRN_ISSUE) && mem_ack;
  assign rd_ptr_inc = rd_ptr + PW'(1);

`ifdef STORE_MISALIGN_TRAP_EN
  assign push = accept && (st_size != SZ_NONE) && !lane_mis;

  // One-cycle pulse for a trapped store, never enqueued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= accept && lane_mis;
  end
`else
  logic unused_lane_mis;
  assign unused_lane_mis = lane_mis;
  assign push            = accept && (st_size != SZ_NONE);
  assign misalign_err    = 1'b0;
`endif

  // Entry built from the current request; low address bits cleared.
  always_comb begin
    push_entry       = '0;
    push_entry.addr  = ENTRY_AW'({st_addr[AW-1:2], 2'b00});
    push_entry.wdata = lane_wdata;
    push_entry.be    = lane_be;
  end

  // Occupancy after this edge.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DRN_IDLE;
    else        state <= state_nxt;
  end

  // Drain FSM next state: issue whenever the buffer will hold an entry.
  always_comb begin
    state_nxt = state;
    case (state)
      DRN_IDLE:  if (count_nxt != '0) state_nxt = DRN_ISSUE;
      DRN_ISSUE: if (count_nxt == '0) state_nxt = DRN_IDLE;
      default:   state_nxt = DRN_IDLE;
    endcase
  end

  // Drain FSM outputs: next head entry for the registered memory port.
  // An empty buffer forwards a new push straight to the head so mem_req
  // rises one edge after acceptance.
  always_comb begin
    head_nxt    = head_q;
    mem_req_nxt = (state_nxt == DRN_ISSUE);
    if (pop) begin
      if (count > CW'(1)) head_nxt = fifo[rd_ptr_inc];
      else if (push)      head_nxt = push_entry;
    end else if ((count == '0) && push) begin
      head_nxt = push_entry;
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_entry;
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_q    <= '0;
      mem_req   <= 1'b0;
      st_ready  <= 1'b1;
      buf_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count     <= count_nxt;
      head_q    <= head_nxt;
      mem_req   <= mem_req_nxt;
      st_ready  <= (count_nxt != CW'(DEPTH));
      buf_empty <= (count_nxt == '0);
    end
  end

  assign mem_addr  = AW'(head_q.addr);
  assign mem_wdata = head_q.wdata;
  assign mem_be    = head_q.be;

endmodule
